scratch_fill_ctrl: RTL and testbench

//   Parametrised successor of the single-word buffer-to-scratchpad read controller.
//   On a start pulse it moves a run-time-selected burst of 0..DEPTH words from the read

---
 rtl/scratch_fill_ctrl_pkg.sv | 23 ++
 rtl/scratch_fill_ctrl.sv | 140 ++++++++++++++
 tb/tb_scratch_fill_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scratch_fill_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// scratch_fill_ctrl_pkg
//   Shared definitions for the buffer-to-scratchpad burst fill controller:
//   FSM state encodings and the scratchpad depth derived from address width.
// ---------------------------------------------------------------------------
package scratch_fill_ctrl_pkg;

    // FSM state encodings (kept as plain 2-bit constants for compatibility
    // with the original single-word controller).
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Number of scratchpad locations addressable with addr_w bits.
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int ADDR_W_DFLT = 4;
    localparam int DEPTH_DFLT  = depth_of(ADDR_W_DFLT);

endpackage

// File: rtl/scratch_fill_ctrl.sv
// ---------------------------------------------------------------------------
// scratch_fill_ctrl
//   Moves a burst of 0..DEPTH words from the read buffer into the scratchpad,
//   starting at a programmable base address that wraps modulo DEPTH.
//   Each word takes a REQ cycle (waiting for buf_valid) and a WRITE cycle.
//
// Ports
//   clk, rst             clock; synchronous active-low reset
//   start, abort         begin a burst (IDLE only) / cancel (highest priority)
//   len, base_addr       burst length 0..DEPTH and first address, latched on start
//   buf_valid, buf_data  read buffer response
//   buf_rd_req           read request to the buffer (high in REQ)
//   sc_wr_en/addr/wdata  scratchpad write port (strobe high in WRITE)
//   busy, done, word_cnt status: not-IDLE, one-cycle completion pulse, words written
// ---------------------------------------------------------------------------
module scratch_fill_ctrl
    import scratch_fill_ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              buf_valid,
    input  logic [DATA_W-1:0] buf_data,
    output logic              buf_rd_req,
    output logic              sc_wr_en,
    output logic [ADDR_W-1:0] sc_addr,
    output logic [DATA_W-1:0] sc_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt
);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   cnt_inc;
    logic              start_ok;

    // abort beats start even in IDLE.
    assign start_ok = start && !abort;
    assign cnt_inc  = word_cnt + (ADDR_W+1)'(1);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = (len == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (buf_valid) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_inc == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;    // DONE lasts exactly one cycle
        endcase
    end

    // Moore outputs decoded from the registered state only.
    assign buf_rd_req = (state_q == REQ);
    assign sc_wr_en   = (state_q == WRITE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    // NOTE: every datapath register is reset, not just the FSM, so a reset
    // mid-burst leaves no stale address, data or count visible afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q    <= '0;
            base_q   <= '0;
            word_cnt <= '0;
            sc_addr  <= '0;
            sc_wdata <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        len_q    <= len;
                        base_q   <= base_addr;
                        word_cnt <= '0;
                    end
                end
                REQ: begin
                    if (!abort && buf_valid) begin
                        sc_wdata <= buf_data;
                        // ADDR_W-bit add: carry is dropped, giving the wrap.
                        sc_addr  <= base_q + word_cnt[ADDR_W-1:0];
                    end
                end
                WRITE: begin
                    // The strobe is already on the port this cycle, so the
                    // word counts even if abort arrives alongside it.
                    word_cnt <= cnt_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scratch_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scratch_fill_ctrl
//   Directed, table-driven bench for scratch_fill_ctrl (DATA_W=16, ADDR_W=4).
// ---------------------------------------------------------------------------
module tb_scratch_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  len;
    logic [3:0]  base_addr;
    logic        buf_valid;
    logic [15:0] buf_data;
    logic        buf_rd_req;
    logic        sc_wr_en;
    logic [3:0]  sc_addr;
    logic [15:0] sc_wdata;
    logic        busy;
    logic        done;
    logic [4:0]  word_cnt;

    scratch_fill_ctrl #(.DATA_W(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .len        (len),
        .base_addr  (base_addr),
        .buf_valid  (buf_valid),
        .buf_data   (buf_data),
        .buf_rd_req (buf_rd_req),
        .sc_wr_en   (sc_wr_en),
        .sc_addr    (sc_addr),
        .sc_wdata   (sc_wdata),
        .busy       (busy),
        .done       (done),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_seen  = 0;
    int done_seen = 0;

    // One record per clock: inputs applied before the edge, outputs expected
    // just after it.
    typedef struct {
        logic        start;
        logic        abort;
        logic [4:0]  len;
        logic [3:0]  base;
        logic        valid;
        logic [15:0] data;
        logic        e_req;
        logic        e_wr;
        logic [3:0]  e_addr;
        logic [15:0] e_wdata;
        logic        e_busy;
        logic        e_done;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int s, input int a, input int l, input int b,
                                input int v, input int d, input int rq, input int wr,
                                input int ad, input int wd, input int bz, input int dn,
                                input int c);
        vec_t r;
        r.start   = s[0];
        r.abort   = a[0];
        r.len     = l[4:0];
        r.base    = b[3:0];
        r.valid   = v[0];
        r.data    = d[15:0];
        r.e_req   = rq[0];
        r.e_wr    = wr[0];
        r.e_addr  = ad[3:0];
        r.e_wdata = wd[15:0];
        r.e_busy  = bz[0];
        r.e_done  = dn[0];
        r.e_cnt   = c[4:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (sc_wr_en) wr_seen++;
        if (done) done_seen++;
    endtask

    task automatic check_outs(input string tag, input logic rq, input logic wr,
                              input logic [3:0] ad, input logic [15:0] wd,
                              input logic bz, input logic dn, input logic [4:0] c);
        check({tag, ".req"},   buf_rd_req, rq);
        check({tag, ".wr"},    sc_wr_en,   wr);
        check({tag, ".addr"},  sc_addr,    ad);
        check({tag, ".wdata"}, sc_wdata,   wd);
        check({tag, ".busy"},  busy,       bz);
        check({tag, ".done"},  done,       dn);
        check({tag, ".cnt"},   word_cnt,   c);
    endtask

    initial begin
        int hits[16];
        int idx;
        int snap;
        bit finished;

        // Test 1: base=2, len=3, valid always high; done in cycle 7.
        vecs.push_back(mk(1,0,3,2, 1,'hA000, 1,0,0,'h0000,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'hA001, 0,1,2,'hA001,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'hA002, 1,0,2,'hA001,1,0,1));
        vecs.push_back(mk(0,0,0,0, 1,'hA003, 0,1,3,'hA003,1,0,1));
        vecs.push_back(mk(0,0,0,0, 1,'hA004, 1,0,3,'hA003,1,0,2));
        vecs.push_back(mk(0,0,0,0, 1,'hA005, 0,1,4,'hA005,1,0,2));
        vecs.push_back(mk(0,0,0,0, 1,'hA006, 0,0,4,'hA005,1,1,3));
        vecs.push_back(mk(0,0,0,0, 1,'hA007, 0,0,4,'hA005,0,0,3));
        // Test 2: base=14, len=4 -> addresses 14,15,0,1.
        vecs.push_back(mk(1,0,4,14,1,'hB000, 1,0,4,'hA005,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'hB001, 0,1,14,'hB001,1,0,0));
        vecs.push_back(mk(0,0,0,0, 1,'hB002, 1,0,14,'hB001,1,0,1));
        vecs.push_back(mk(0,0,0,0, 1,'hB003, 0,1,15,'hB003,1,0,1));
        vecs.push_back(mk(0,0,0,0, 1,'hB004, 1,0,15,'hB003,1,0,2));
        vecs.push_back(mk(0,0,0,0, 1,'hB005, 0,1,0,'hB005,1,0,2));
        vecs.push_back(mk(0,0,0,0, 1,'hB006, 1,0,0,'hB005,1,0,3));
        vecs.push_back(mk(0,0,0,0, 1,'hB007, 0,1,1,'hB007,1,0,3));
        vecs.push_back(mk(0,0,0,0, 1,'hB008, 0,0,1,'hB007,1,1,4));
        vecs.push_back(mk(0,0,0,0, 1,'hB009, 0,0,1,'hB007,0,0,4));
        // Test 4: len=0 -> straight to DONE, busy for one cycle.
        vecs.push_back(mk(1,0,0,5, 1,'hC000, 0,0,1,'hB007,1,1,0));
        vecs.push_back(mk(0,0,0,0, 1,'hC001, 0,0,1,'hB007,0,0,0));

        // Reset state.
        rst = 1'b0; start = 1'b0; abort = 1'b0; len = '0; base_addr = '0;
        buf_valid = 1'b0; buf_data = '0;
        step();
        step();
        check_outs("reset", 0, 0, 0, 16'h0, 0, 0, 0);
        rst = 1'b1;
        step();
        check_outs("post_reset", 0, 0, 0, 16'h0, 0, 0, 0);

        // Table-driven tests 1, 2, 4.
        wr_seen = 0;
        done_seen = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start; abort = vecs[i].abort; len = vecs[i].len;
            base_addr = vecs[i].base; buf_valid = vecs[i].valid; buf_data = vecs[i].data;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_wr, vecs[i].e_addr,
                       vecs[i].e_wdata, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_cnt);
        end
        check("tbl.writes", wr_seen, 7);
        check("tbl.dones",  done_seen, 3);

        // Test 3: stall the second REQ for 5 cycles.
        wr_seen = 0; done_seen = 0;
        start = 1; len = 3; base_addr = 8; buf_valid = 1; buf_data = 16'hC100;
        step();
        start = 0; buf_data = 16'hC101;
        step();
        check_outs("stall.w0", 0, 1, 8, 16'hC101, 1, 0, 0);
        buf_valid = 0; buf_data = 16'hD0FF;
        step();
        for (int k = 0; k < 5; k++) begin
            buf_data = 16'hD000 + 16'(k);
            step();
            check_outs($sformatf("stall.wait%0d", k), 1, 0, 8, 16'hC101, 1, 0, 1);
        end
        buf_valid = 1; buf_data = 16'hC102;
        step();
        check_outs("stall.w1", 0, 1, 9, 16'hC102, 1, 0, 1);
        buf_data = 16'hC1FF;
        step();
        buf_data = 16'hC103;
        step();
        check_outs("stall.w2", 0, 1, 10, 16'hC103, 1, 0, 2);
        step();
        check_outs("stall.done", 0, 0, 10, 16'hC103, 1, 1, 3);
        step();
        check("stall.writes", wr_seen, 3);
        check("stall.dones",  done_seen, 1);

        // Test 5: starts while busy ignored; abort in second REQ.
        wr_seen = 0; done_seen = 0;
        start = 1; len = 4; base_addr = 0; buf_valid = 1; buf_data = 16'hE000;
        step();
        start = 1; len = 2; base_addr = 7; buf_data = 16'hE001;
        step();
        check_outs("abort.w0", 0, 1, 0, 16'hE001, 1, 0, 0);
        buf_data = 16'hE002;
        step();
        check_outs("abort.req2", 1, 0, 0, 16'hE001, 1, 0, 1);
        abort = 1; buf_data = 16'hE003;
        step();
        check_outs("abort.idle", 0, 0, 0, 16'hE001, 0, 0, 1);
        abort = 0; start = 0;
        step();
        check_outs("abort.hold", 0, 0, 0, 16'hE001, 0, 0, 1);
        abort = 1; start = 1; len = 3;
        step();
        check_outs("abort.start_idle", 0, 0, 0, 16'hE001, 0, 0, 1);
        abort = 0; start = 0;
        step();
        check("abort.writes", wr_seen, 1);
        check("abort.dones",  done_seen, 0);

        // Test 6: reset mid-WRITE, then a full-depth burst.
        done_seen = 0;
        start = 1; len = 4; base_addr = 3; buf_valid = 1; buf_data = 16'h7777;
        step();
        start = 0;
        step();
        check("rst6.in_write", sc_wr_en, 1);
        rst = 0;
        step();
        check_outs("rst6.cleared", 0, 0, 0, 16'h0, 0, 0, 0);
        rst = 1;
        step();
        check_outs("rst6.idle", 0, 0, 0, 16'h0, 0, 0, 0);
        check("rst6.no_done", done_seen, 0);

        foreach (hits[a]) hits[a] = 0;
        idx = 0; snap = 0; finished = 0;
        start = 1; len = 5'd16; base_addr = 5; buf_valid = 1; buf_data = 16'h5A00;
        step();
        start = 0;
        for (int c = 0; c < 100 && !finished; c++) begin
            buf_data = 16'h5A00 | 16'(idx);
            @(posedge clk);
            #1;
            if (sc_wr_en) begin
                check($sformatf("full.addr%0d", idx), sc_addr, 32'((5 + idx) % 16));
                check($sformatf("full.data%0d", idx), sc_wdata, 32'(16'h5A00 | 16'(idx)));
                hits[sc_addr]++;
                idx++;
            end
            if (done) begin
                snap++;
                finished = 1;
            end
        end
        check("full.finished", finished, 1);
        check("full.writes",   idx, 16);
        check("full.cnt",      word_cnt, 16);
        foreach (hits[a]) check($sformatf("full.hit%0d", a), hits[a], 1);
        step();
        check("full.idle", busy, 0);
        check("full.one_done", snap + int'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
